ova_dvp_tx: RTL and testbench

// - DVP camera-side transmitter: serialises a 16-bit pixel stream into 8-bit bytes with href/vsync framing, clocked by i_pclk.
// - Mirror of the capture path. High byte goes first, then low byte, so a capture block that forms {byte_n-1, byte_n} recovers the pixel.
// - Used as an on-chip camera model for capture/CNN bring-up, and as a DVP output for re-streaming processed frames.

---
 rtl/ova_pkg.sv | 20 ++
 rtl/ova_dvp_tx_if.sv | 22 ++
 rtl/ova_dvp_timing.sv | 135 +++++++++++++
 rtl/ova_dvp_tx.sv | 91 +++++++++
 tb/tb_ova_dvp_tx.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ova_pkg.sv
// Shared widths and FSM state type for the DVP transmitter.
package ova_pkg;

  localparam int DVP_BYTE_W = 8;
  localparam int PIX_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFRONT
  } ova_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ova_dvp_tx_if.sv
// Pixel-in / DVP-out signal bundle of the transmitter.
interface ova_dvp_tx_if;
  import ova_pkg::*;

  logic [PIX_W-1:0]      i_pix_data;
  logic                  i_pix_vld;
  logic                  o_pix_rdy;
  logic [DVP_BYTE_W-1:0] o_data;
  logic                  o_href;
  logic                  o_vsync;

  modport master (
    input  i_pix_data, i_pix_vld,
    output o_pix_rdy, o_data, o_href, o_vsync
  );

  modport slave (
    output i_pix_data, i_pix_vld,
    input  o_pix_rdy, o_data, o_href, o_vsync
  );

endinterface

// File: rtl/ova_dvp_timing.sv
// Frame/line timing FSM. The *_d outputs describe the cycle after this one,
// so the top can register them and stay aligned with the FSM state.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | waiting for i_en
// ST_VSYNC  | vsync high, VSYNC_CYC cycles
// ST_VBACK  | vertical back porch, V_BACK cycles
// ST_ACTIVE | href high, 2*H_ACTIVE byte cycles
// ST_HBLANK | href low after a line, H_BLANK cycles
// ST_VFRONT | vertical front porch, V_FRONT cycles, frame_done at end
module ova_dvp_timing
  import ova_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_CYC = 3136,
  parameter int V_BACK    = 100,
  parameter int V_FRONT   = 100
) (
  input  logic i_pclk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_pix_rdy,
  output logic o_href_d,
  output logic o_vsync_d,
  output logic o_lo_d,
  output logic o_done_d
);

  localparam int BYTES   = 2 * H_ACTIVE;
  localparam int CYC_MAX = max2(max2(VSYNC_CYC, V_BACK), max2(H_BLANK, V_FRONT));
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int BYTE_W  = $clog2(BYTES + 1);
  localparam int LINE_W  = $clog2(V_ACTIVE + 1);

  localparam logic [CYC_W-1:0]  VS_LAST   = CYC_W'(VSYNC_CYC - 1);
  localparam logic [CYC_W-1:0]  VB_LAST   = CYC_W'(V_BACK - 1);
  localparam logic [CYC_W-1:0]  HB_LAST   = CYC_W'(H_BLANK - 1);
  localparam logic [CYC_W-1:0]  VF_LAST   = CYC_W'(V_FRONT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);

  ova_state_e        state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      byte_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    byte_d  = byte_q;
    line_d  = line_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_en) state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (cyc_q == VS_LAST) begin
          cyc_d   = '0;
          state_d = ST_VBACK;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_VBACK: begin
        if (cyc_q == VB_LAST) begin
          cyc_d   = '0;
          state_d = ST_ACTIVE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (byte_q == BYTE_LAST) begin
          byte_d  = '0;
          state_d = ST_HBLANK;
        end else begin
          byte_d = byte_q + BYTE_W'(1);
        end
      end
      ST_HBLANK: begin
        if (cyc_q == HB_LAST) begin
          cyc_d = '0;
          // line_q is the index of the line just sent
          if (line_q == LINE_LAST) begin
            line_d  = '0;
            state_d = ST_VFRONT;
          end else begin
            line_d  = line_q + LINE_W'(1);
            state_d = ST_ACTIVE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_VFRONT: begin
        if (cyc_q == VF_LAST) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobe one cycle ahead of every high-byte slot
    o_pix_rdy = ((state_q == ST_VBACK)  && (cyc_q == VB_LAST)) ||
                ((state_q == ST_HBLANK) && (cyc_q == HB_LAST) && (line_q != LINE_LAST)) ||
                ((state_q == ST_ACTIVE) && byte_q[0] && (byte_q != BYTE_LAST));

    o_href_d  = (state_d == ST_ACTIVE);
    o_vsync_d = (state_d == ST_VSYNC);
    o_lo_d    = (state_d == ST_ACTIVE) && byte_d[0];
    o_done_d  = (state_d == ST_VFRONT) && (cyc_d == VF_LAST);
  end

endmodule

// File: rtl/ova_dvp_tx.sv
// DVP camera-side transmitter: 16-bit pixels out as high/low byte pairs
// with registered href/vsync framing.
module ova_dvp_tx
  import ova_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_CYC = 3136,
  parameter int V_BACK    = 100,
  parameter int V_FRONT   = 100
) (
  input  logic         i_pclk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr_err,
  output logic         o_frame_done,
  output logic         o_underflow,
  ova_dvp_tx_if.master dvp
);

  logic                  pix_rdy;
  logic                  href_d, vsync_d, lo_d, done_d;
  logic                  href_q, vsync_q, done_q;
  logic                  uf_d, uf_q;
  logic [PIX_W-1:0]      pix_in, pix_d, pix_q;
  logic [DVP_BYTE_W-1:0] data_d, data_q;

  ova_dvp_timing #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .H_BLANK   (H_BLANK),
    .VSYNC_CYC (VSYNC_CYC),
    .V_BACK    (V_BACK),
    .V_FRONT   (V_FRONT)
  ) u_timing (
    .i_pclk    (i_pclk),
    .rst_n     (rst_n),
    .i_en      (i_en),
    .o_pix_rdy (pix_rdy),
    .o_href_d  (href_d),
    .o_vsync_d (vsync_d),
    .o_lo_d    (lo_d),
    .o_done_d  (done_d)
  );

  always_comb begin
    // A missing pixel still occupies its slot, sent as zero
    pix_in = dvp.i_pix_vld ? dvp.i_pix_data : '0;
    pix_d  = pix_rdy ? pix_in : pix_q;

    // High-byte slots always follow a strobe, so that byte bypasses pix_q
    data_d = '0;
    if (href_d) begin
      data_d = lo_d ? pix_q[DVP_BYTE_W-1:0] : pix_in[PIX_W-1 -: DVP_BYTE_W];
    end

    uf_d = uf_q;
    if (pix_rdy && !dvp.i_pix_vld) begin
      uf_d = 1'b1;
    end else if (i_clr_err) begin
      uf_d = 1'b0;
    end
  end

  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q   <= '0;
      data_q  <= '0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      done_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      data_q  <= data_d;
      href_q  <= href_d;
      vsync_q <= vsync_d;
      done_q  <= done_d;
      uf_q    <= uf_d;
    end
  end

  assign dvp.o_pix_rdy = pix_rdy;
  assign dvp.o_data    = data_q;
  assign dvp.o_href    = href_q;
  assign dvp.o_vsync   = vsync_q;
  assign o_frame_done  = done_q;
  assign o_underflow   = uf_q;

endmodule

// File: tb/tb_ova_dvp_tx.sv
// Randomised frame-level bench for ova_dvp_tx with a trace-based reference model.
module tb_ova_dvp_tx;

  localparam int HA = 4, VA = 2, HB = 3, VS = 5, VB = 2, VF = 2;
  localparam int NPIX    = HA * VA;
  localparam int FRAME_L = VS + VB + VA * (2 * HA + HB) + VF;

  logic i_pclk = 1'b0;
  logic rst_n = 1'b0;
  logic i_en = 1'b0;
  logic i_clr_err = 1'b0;
  logic o_frame_done, o_underflow;

  ova_dvp_tx_if dvp_if();

  ova_dvp_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_CYC(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .i_pclk       (i_pclk),
    .rst_n        (rst_n),
    .i_en         (i_en),
    .i_clr_err    (i_clr_err),
    .o_frame_done (o_frame_done),
    .o_underflow  (o_underflow),
    .dvp          (dvp_if)
  );

  always #5 i_pclk = ~i_pclk;

  int cyc = 0;
  always @(posedge i_pclk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] pix [NPIX];
  bit          absent [NPIX];
  // per cycle: {vsync, href, data[7:0], frame_done, pix_rdy}
  logic [11:0] exp_tr [FRAME_L];
  bit          exp_hi [FRAME_L];
  bit          exp_uf = 1'b0;
  logic [15:0] cap_q [$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] sent_pix(input int p);
    return absent[p] ? 16'h0000 : pix[p];
  endfunction

  task automatic drive_fifo(input int k);
    if (k < NPIX) begin
      dvp_if.i_pix_vld  = !absent[k];
      dvp_if.i_pix_data = absent[k] ? 16'($urandom) : pix[k];
    end else begin
      dvp_if.i_pix_vld  = 1'b0;
      dvp_if.i_pix_data = 16'($urandom);
    end
  endtask

  // Expected frame built segment by segment from the frame layout
  task automatic build_trace();
    int i;
    logic [15:0] px;
    i = 0;
    for (int c = 0; c < VS; c++) begin exp_tr[i] = 12'h800; exp_hi[i] = 0; i++; end
    for (int c = 0; c < VB; c++) begin exp_tr[i] = 12'h000; exp_hi[i] = 0; i++; end
    for (int l = 0; l < VA; l++) begin
      for (int b = 0; b < 2 * HA; b++) begin
        px = sent_pix(l * HA + b / 2);
        exp_tr[i] = {1'b0, 1'b1, (b % 2 == 0) ? px[15:8] : px[7:0], 2'b00};
        exp_hi[i] = (b % 2 == 0);
        i++;
      end
      for (int c = 0; c < HB; c++) begin exp_tr[i] = 12'h000; exp_hi[i] = 0; i++; end
    end
    for (int c = 0; c < VF; c++) begin
      exp_tr[i] = {10'b0, (c == VF - 1), 1'b0};
      exp_hi[i] = 0;
      i++;
    end
    for (int j = 0; j < FRAME_L - 1; j++) exp_tr[j][0] = exp_hi[j + 1];
  endtask

  task automatic randomize_frame(input int absent_odds);
    for (int p = 0; p < NPIX; p++) begin
      pix[p]    = 16'($urandom);
      absent[p] = (absent_odds > 0) && ($urandom_range(0, absent_odds - 1) == 0);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after the frame
  task automatic run_frame(input bit hold_en, input int clr_mode,
                           output int start_cyc, output int done_cyc);
    int k, ms, strobes, drop_at;
    bit adv, cap_ph;
    logic [7:0]  cap_hi;
    logic [11:0] obs;
    k = 0; ms = 0; strobes = 0; adv = 0; cap_ph = 0; cap_hi = '0;
    start_cyc = -1; done_cyc = -1;
    drop_at = $urandom_range(0, FRAME_L - 1);
    build_trace();
    cap_q.delete();
    i_en = 1'b1;
    drive_fifo(0);
    for (int i = 0; i < FRAME_L; i++) begin
      @(posedge i_pclk); #1;
      i_clr_err = 1'b0;
      if (adv) begin k++; drive_fifo(k); end
      adv = 0;
      @(negedge i_pclk);
      if (i == 0) start_cyc = cyc;
      obs = {dvp_if.o_vsync, dvp_if.o_href, dvp_if.o_data, o_frame_done, dvp_if.o_pix_rdy};
      check_val($sformatf("trace[%0d]", i), 32'(obs), 32'(exp_tr[i]));
      check_val($sformatf("underflow[%0d]", i), 32'(o_underflow), 32'(exp_uf));
      if (o_frame_done) done_cyc = cyc;
      if (dvp_if.o_href) begin
        if (!cap_ph) cap_hi = dvp_if.o_data;
        else cap_q.push_back({cap_hi, dvp_if.o_data});
        cap_ph = !cap_ph;
      end
      if (dvp_if.o_pix_rdy) begin adv = 1; strobes++; end
      if (clr_mode == 1)      i_clr_err = exp_tr[i][0] && (ms < NPIX) && absent[ms];
      else if (clr_mode == 2) i_clr_err = ($urandom_range(0, 3) == 0);
      // a missing pixel sets the flag even when a clear arrives with it
      if (exp_tr[i][0] && (ms < NPIX) && absent[ms]) exp_uf = 1'b1;
      else if (i_clr_err) exp_uf = 1'b0;
      if (exp_tr[i][0]) ms++;
      if (!hold_en && i == drop_at) i_en = 1'b0;
    end
    check_val("strobes", 32'(strobes), 32'(NPIX));
    check_val("loopback_count", 32'(cap_q.size()), 32'(NPIX));
    for (int p = 0; p < cap_q.size() && p < NPIX; p++)
      check_val($sformatf("loopback[%0d]", p), 32'(cap_q[p]), 32'(sent_pix(p)));
    @(posedge i_pclk); #1;
    i_clr_err = 1'b0;
    @(negedge i_pclk);
    check_val("idle_gap", 32'({dvp_if.o_vsync, dvp_if.o_href, dvp_if.o_pix_rdy, o_frame_done}), 32'h0);
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(negedge i_pclk);
      check_val(tag, 32'({dvp_if.o_vsync, dvp_if.o_href, dvp_if.o_pix_rdy, dvp_if.o_data}), 32'h0);
    end
  endtask

  int s_cyc [4];
  int d_cyc [4];
  int s0, d0;

  initial begin
    dvp_if.i_pix_vld  = 1'b0;
    dvp_if.i_pix_data = '0;
    repeat (3) @(negedge i_pclk);
    check_val("reset_outputs", 32'({dvp_if.o_data, dvp_if.o_href, dvp_if.o_vsync,
              dvp_if.o_pix_rdy, o_frame_done, o_underflow}), 32'h0);
    rst_n = 1'b1;
    check_idle(4, "idle_no_en");

    // directed frame: A1B2, A3B4, ... all present
    for (int p = 0; p < NPIX; p++) begin
      pix[p]    = 16'hA1B2 + 16'(p) * 16'h0202;
      absent[p] = 1'b0;
    end
    run_frame(1'b0, 0, s0, d0);
    check_idle(3, "idle_after_drop");

    // FIFO empty on the third pixel of the first line
    randomize_frame(0);
    absent[2] = 1'b1;
    run_frame(1'b0, 0, s0, d0);
    check_idle(2, "idle_after_uf");
    check_val("uf_sticky", 32'(o_underflow), 32'h1);
    i_clr_err = 1'b1;
    @(posedge i_pclk); #1;
    i_clr_err = 1'b0;
    exp_uf = 1'b0;
    @(negedge i_pclk);
    check_val("uf_clear", 32'(o_underflow), 32'h0);

    // back-to-back frames; the first has a clear on the same cycle as a new underflow
    for (int f = 0; f < 4; f++) begin
      randomize_frame(f == 0 ? 0 : 6);
      if (f == 0) absent[$urandom_range(0, NPIX - 1)] = 1'b1;
      run_frame(f < 3, (f == 0) ? 1 : int'($urandom_range(0, 2)), s_cyc[f], d_cyc[f]);
      if (f == 0) check_val("uf_set_wins", 32'(o_underflow), 32'h1);
    end
    for (int f = 1; f < 4; f++) begin
      check_val($sformatf("frame_period[%0d]", f), 32'(s_cyc[f] - s_cyc[f-1]), 32'(FRAME_L + 1));
      check_val($sformatf("done_to_vsync[%0d]", f), 32'(s_cyc[f] - d_cyc[f-1]), 32'h2);
    end
    check_idle(3, "idle_after_chain");

    // asynchronous reset in the middle of an active line
    randomize_frame(0);
    drive_fifo(0);
    i_en = 1'b1;
    for (int t = 0; t < 4 * FRAME_L && !dvp_if.o_href; t++) @(negedge i_pclk);
    check_val("href_seen", 32'(dvp_if.o_href), 32'h1);
    @(negedge i_pclk);
    #2 rst_n = 1'b0;
    #1 check_val("async_reset", 32'({dvp_if.o_data, dvp_if.o_href, dvp_if.o_vsync,
                 dvp_if.o_pix_rdy, o_frame_done, o_underflow}), 32'h0);
    i_en   = 1'b0;
    exp_uf = 1'b0;
    @(negedge i_pclk);
    rst_n = 1'b1;
    check_idle(5, "idle_after_reset");

    randomize_frame(5);
    run_frame(1'b0, 2, s0, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
